// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: load-use scoreboard, stall arbitration,
// branch/jump flush queueing and a saturating stall-cycle counter.
module pipe_ctrl #(
  parameter int REG_NUM = 32,
  parameter int ADDR_W  = 5,
  parameter int PC_W    = 32,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_from_id,
  input  logic              stallreq_from_ex,
  input  logic              stallreq_from_mem,
  input  logic              id_reg1_read_i,
  input  logic [ADDR_W-1:0] id_reg1_addr_i,
  input  logic              id_reg2_read_i,
  input  logic [ADDR_W-1:0] id_reg2_addr_i,
  input  logic              id_wreg_i,
  input  logic [ADDR_W-1:0] id_wd_i,
  input  logic              id_is_load_i,
  input  logic              mem_load_done_i,
  input  logic [ADDR_W-1:0] mem_load_wd_i,
  input  logic              flush_req_i,
  input  logic [PC_W-1:0]   flush_target_i,
  output logic [5:0]        stall,
  output logic              flush,
  output logic [PC_W-1:0]   new_pc,
  output logic              sb_stall_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  logic [REG_NUM-1:0] pending_q, pending_d;
  logic               pend_flush_q, pend_flush_d;
  logic [PC_W-1:0]    pend_pc_q, pend_pc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               hard_stall;
  logic               issue;

  assign hard_stall  = stallreq_from_mem | stallreq_from_ex;
  assign stall_cnt_o = cnt_q;

  // A flush is only taken when mem/ex are not holding the pipe; it overrides
  // the decode stall because the instruction in id is being killed anyway.
  always_comb begin
    sb_stall_o = 1'b0;
    stall      = 6'b000000;
    flush      = 1'b0;
    new_pc     = '0;
    if (rst) begin
      sb_stall_o = (id_reg1_read_i & pending_q[id_reg1_addr_i]) |
                   (id_reg2_read_i & pending_q[id_reg2_addr_i]);
      if (stallreq_from_mem) begin
        stall = 6'b011111;
      end else if (stallreq_from_ex) begin
        stall = 6'b001111;
      end else if (flush_req_i || pend_flush_q) begin
        flush  = 1'b1;
        new_pc = flush_req_i ? flush_target_i : pend_pc_q;
      end else if (stallreq_from_id || sb_stall_o) begin
        stall = 6'b000111;
      end
    end
  end

  assign issue = ~stall[2] & ~flush;

  // Clear first, then set, so a same-cycle set of the same register wins.
  always_comb begin
    pending_d = pending_q;
    if (mem_load_done_i && (mem_load_wd_i != '0)) begin
      pending_d[mem_load_wd_i] = 1'b0;
    end
    if (issue && id_wreg_i && id_is_load_i && (id_wd_i != '0)) begin
      pending_d[id_wd_i] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_comb begin
    pend_flush_d = pend_flush_q;
    pend_pc_d    = pend_pc_q;
    if (hard_stall && flush_req_i) begin
      pend_flush_d = 1'b1;
      pend_pc_d    = flush_target_i;
    end else if (flush) begin
      pend_flush_d = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if ((stall != 6'b000000) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q    <= '0;
      pend_flush_q <= 1'b0;
      pend_pc_q    <= '0;
      cnt_q        <= '0;
    end else begin
      pending_q    <= pending_d;
      pend_flush_q <= pend_flush_d;
      pend_pc_q    <= pend_pc_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed, table-driven bench for pipe_ctrl: one full-width instance plus a
// CNT_W=4 instance on the same inputs for counter saturation.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_from_id, stallreq_from_ex, stallreq_from_mem;
  logic        id_reg1_read_i, id_reg2_read_i, id_wreg_i, id_is_load_i;
  logic [4:0]  id_reg1_addr_i, id_reg2_addr_i, id_wd_i, mem_load_wd_i;
  logic        mem_load_done_i, flush_req_i;
  logic [31:0] flush_target_i;

  logic [5:0]  stall, s_stall;
  logic        flush, s_flush, sb_stall_o, s_sb;
  logic [31:0] new_pc, s_new_pc, stall_cnt_o;
  logic [3:0]  s_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.REG_NUM(32), .ADDR_W(5), .PC_W(32), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst),
    .stallreq_from_id(stallreq_from_id), .stallreq_from_ex(stallreq_from_ex),
    .stallreq_from_mem(stallreq_from_mem),
    .id_reg1_read_i(id_reg1_read_i), .id_reg1_addr_i(id_reg1_addr_i),
    .id_reg2_read_i(id_reg2_read_i), .id_reg2_addr_i(id_reg2_addr_i),
    .id_wreg_i(id_wreg_i), .id_wd_i(id_wd_i), .id_is_load_i(id_is_load_i),
    .mem_load_done_i(mem_load_done_i), .mem_load_wd_i(mem_load_wd_i),
    .flush_req_i(flush_req_i), .flush_target_i(flush_target_i),
    .stall(stall), .flush(flush), .new_pc(new_pc),
    .sb_stall_o(sb_stall_o), .stall_cnt_o(stall_cnt_o)
  );

  pipe_ctrl #(.REG_NUM(32), .ADDR_W(5), .PC_W(32), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst),
    .stallreq_from_id(stallreq_from_id), .stallreq_from_ex(stallreq_from_ex),
    .stallreq_from_mem(stallreq_from_mem),
    .id_reg1_read_i(id_reg1_read_i), .id_reg1_addr_i(id_reg1_addr_i),
    .id_reg2_read_i(id_reg2_read_i), .id_reg2_addr_i(id_reg2_addr_i),
    .id_wreg_i(id_wreg_i), .id_wd_i(id_wd_i), .id_is_load_i(id_is_load_i),
    .mem_load_done_i(mem_load_done_i), .mem_load_wd_i(mem_load_wd_i),
    .flush_req_i(flush_req_i), .flush_target_i(flush_target_i),
    .stall(s_stall), .flush(s_flush), .new_pc(s_new_pc),
    .sb_stall_o(s_sb), .stall_cnt_o(s_cnt)
  );

  typedef struct {
    logic [2:0]  req;   // {mem, ex, id}
    logic        r1rd;
    logic [4:0]  r1a;
    logic        r2rd;
    logic [4:0]  r2a;
    logic        wl;    // decode holds a load writing wd
    logic [4:0]  wd;
    logic        done;
    logic [4:0]  dwd;
    logic        fr;
    logic [31:0] ft;
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;
    logic        e_sb;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [2:0] req, logic r1rd, logic [4:0] r1a,
                              logic r2rd, logic [4:0] r2a, logic wl, logic [4:0] wd,
                              logic done, logic [4:0] dwd, logic fr, logic [31:0] ft,
                              logic [5:0] es, logic ef, logic [31:0] epc,
                              logic esb, logic [31:0] ecnt);
    vec_t v;
    v.req = req; v.r1rd = r1rd; v.r1a = r1a; v.r2rd = r2rd; v.r2a = r2a;
    v.wl = wl; v.wd = wd; v.done = done; v.dwd = dwd; v.fr = fr; v.ft = ft;
    v.e_stall = es; v.e_flush = ef; v.e_pc = epc; v.e_sb = esb; v.e_cnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    {stallreq_from_mem, stallreq_from_ex, stallreq_from_id} = v.req;
    id_reg1_read_i = v.r1rd; id_reg1_addr_i = v.r1a;
    id_reg2_read_i = v.r2rd; id_reg2_addr_i = v.r2a;
    id_wreg_i = v.wl; id_is_load_i = v.wl; id_wd_i = v.wd;
    mem_load_done_i = v.done; mem_load_wd_i = v.dwd;
    flush_req_i = v.fr; flush_target_i = v.ft;
  endtask

  task automatic idle();
    drive(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 6'h0, 0, 0, 0, 0));
  endtask

  initial begin
    rst = 1'b0;
    idle();

    // Reset held with random inputs: everything reads zero.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      {stallreq_from_mem, stallreq_from_ex, stallreq_from_id} = 3'($urandom);
      {id_reg1_read_i, id_reg2_read_i, id_wreg_i, id_is_load_i} = 4'($urandom);
      {id_reg1_addr_i, id_reg2_addr_i, id_wd_i, mem_load_wd_i} = 20'($urandom);
      {mem_load_done_i, flush_req_i} = 2'($urandom);
      flush_target_i = $urandom;
      #2;
      chk("rst_stall", 32'(stall), 32'h0);
      chk("rst_flush", 32'(flush), 32'h0);
      chk("rst_new_pc", new_pc, 32'h0);
      chk("rst_cnt", stall_cnt_o, 32'h0);
    end
    @(negedge clk);
    idle();
    rst = 1'b1;

    //            req     r1rd r1a r2rd r2a wl wd done dwd fr ft            stall   fl pc          sb cnt
    tbl.push_back(mk(3'b000, 0, 0,  0, 0,  0, 0,  0, 0,  0, 32'h0,   6'h00, 0, 32'h0,   0, 0));  // idle
    tbl.push_back(mk(3'b000, 0, 0,  0, 0,  1, 5,  0, 0,  0, 32'h0,   6'h00, 0, 32'h0,   0, 0));  // load x5
    tbl.push_back(mk(3'b000, 1, 5,  0, 0,  0, 0,  0, 0,  0, 32'h0,   6'h07, 0, 32'h0,   1, 0));  // use x5
    tbl.push_back(mk(3'b000, 1, 5,  0, 0,  0, 0,  0, 0,  0, 32'h0,   6'h07, 0, 32'h0,   1, 1));
    tbl.push_back(mk(3'b000, 1, 5,  0, 0,  0, 0,  1, 5,  0, 32'h0,   6'h07, 0, 32'h0,   1, 2));  // done x5
    tbl.push_back(mk(3'b000, 1, 5,  0, 0,  0, 0,  0, 0,  0, 32'h0,   6'h00, 0, 32'h0,   0, 3));  // freed
    tbl.push_back(mk(3'b000, 0, 0,  0, 0,  1, 0,  0, 0,  0, 32'h0,   6'h00, 0, 32'h0,   0, 3));  // load x0
    tbl.push_back(mk(3'b000, 0, 0,  1, 0,  0, 0,  0, 0,  0, 32'h0,   6'h00, 0, 32'h0,   0, 3));  // read x0
    tbl.push_back(mk(3'b000, 0, 0,  0, 0,  1, 7,  0, 0,  0, 32'h0,   6'h00, 0, 32'h0,   0, 3));  // load x7
    tbl.push_back(mk(3'b000, 0, 0,  0, 0,  1, 7,  1, 7,  0, 32'h0,   6'h00, 0, 32'h0,   0, 3));  // set+clear x7
    tbl.push_back(mk(3'b000, 0, 0,  1, 7,  0, 0,  0, 0,  0, 32'h0,   6'h07, 0, 32'h0,   1, 3));  // x7 still pending
    tbl.push_back(mk(3'b000, 0, 0,  1, 7,  0, 0,  1, 7,  0, 32'h0,   6'h07, 0, 32'h0,   1, 4));
    tbl.push_back(mk(3'b000, 0, 0,  1, 7,  0, 0,  0, 0,  0, 32'h0,   6'h00, 0, 32'h0,   0, 5));
    tbl.push_back(mk(3'b111, 0, 0,  0, 0,  0, 0,  0, 0,  0, 32'h0,   6'h1F, 0, 32'h0,   0, 5));  // priority
    tbl.push_back(mk(3'b011, 0, 0,  0, 0,  0, 0,  0, 0,  0, 32'h0,   6'h0F, 0, 32'h0,   0, 6));
    tbl.push_back(mk(3'b001, 0, 0,  0, 0,  0, 0,  0, 0,  0, 32'h0,   6'h07, 0, 32'h0,   0, 7));
    tbl.push_back(mk(3'b000, 0, 0,  0, 0,  0, 0,  0, 0,  0, 32'h0,   6'h00, 0, 32'h0,   0, 8));
    tbl.push_back(mk(3'b010, 0, 0,  0, 0,  0, 0,  0, 0,  1, 32'h100, 6'h0F, 0, 32'h0,   0, 8));  // deferred
    tbl.push_back(mk(3'b010, 0, 0,  0, 0,  0, 0,  0, 0,  1, 32'h200, 6'h0F, 0, 32'h0,   0, 9));  // overwrite
    tbl.push_back(mk(3'b010, 0, 0,  0, 0,  0, 0,  0, 0,  0, 32'h0,   6'h0F, 0, 32'h0,   0, 10));
    tbl.push_back(mk(3'b000, 0, 0,  0, 0,  1, 9,  0, 0,  0, 32'h0,   6'h00, 1, 32'h200, 0, 11)); // pending flush
    tbl.push_back(mk(3'b000, 0, 0,  0, 0,  0, 0,  0, 0,  0, 32'h0,   6'h00, 0, 32'h0,   0, 11)); // one cycle only
    tbl.push_back(mk(3'b000, 1, 9,  0, 0,  0, 0,  0, 0,  0, 32'h0,   6'h00, 0, 32'h0,   0, 11)); // x9 never issued
    tbl.push_back(mk(3'b001, 0, 0,  0, 0,  0, 0,  0, 0,  1, 32'h300, 6'h00, 1, 32'h300, 0, 11)); // immediate
    tbl.push_back(mk(3'b000, 0, 0,  0, 0,  0, 0,  0, 0,  0, 32'h0,   6'h00, 0, 32'h0,   0, 11));
    tbl.push_back(mk(3'b100, 0, 0,  0, 0,  0, 0,  0, 0,  1, 32'h400, 6'h1F, 0, 32'h0,   0, 11)); // deferred by mem
    tbl.push_back(mk(3'b000, 0, 0,  0, 0,  0, 0,  0, 0,  0, 32'h0,   6'h00, 1, 32'h400, 0, 12));
    tbl.push_back(mk(3'b000, 0, 0,  0, 0,  0, 0,  0, 0,  0, 32'h0,   6'h00, 0, 32'h0,   0, 12));
    tbl.push_back(mk(3'b010, 0, 0,  0, 0,  0, 0,  0, 0,  1, 32'h500, 6'h0F, 0, 32'h0,   0, 12)); // pend before reset

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      #2;
      chk($sformatf("v%0d_stall", i), 32'(stall), 32'(tbl[i].e_stall));
      chk($sformatf("v%0d_flush", i), 32'(flush), 32'(tbl[i].e_flush));
      chk($sformatf("v%0d_new_pc", i), new_pc, tbl[i].e_pc);
      chk($sformatf("v%0d_sb", i), 32'(sb_stall_o), 32'(tbl[i].e_sb));
      chk($sformatf("v%0d_cnt", i), stall_cnt_o, tbl[i].e_cnt);
      chk($sformatf("v%0d_cnt4", i), 32'(s_cnt), (tbl[i].e_cnt > 15) ? 32'd15 : tbl[i].e_cnt);
    end

    // Asynchronous reset mid-operation drops the pending flush and counter.
    @(negedge clk);
    idle();
    #1 rst = 1'b0;
    #1;
    chk("async_rst_cnt", stall_cnt_o, 32'h0);
    rst = 1'b1;
    #1;
    chk("post_rst_flush", 32'(flush), 32'h0);
    chk("post_rst_new_pc", new_pc, 32'h0);
    @(negedge clk);
    #2;
    chk("post_rst_flush2", 32'(flush), 32'h0);
    chk("post_rst_stall", 32'(stall), 32'h0);

    // Long ex stall: the 4-bit counter saturates at 15 and holds.
    @(negedge clk);
    stallreq_from_ex = 1'b1;
    repeat (14) @(negedge clk);
    #2;
    chk("sat_cnt4_14", 32'(s_cnt), 32'd14);
    repeat (6) @(negedge clk);
    #2;
    chk("sat_cnt4_20", 32'(s_cnt), 32'd15);
    chk("sat_cnt32_20", stall_cnt_o, 32'd20);
    repeat (3) @(negedge clk);
    #2;
    chk("sat_cnt4_hold", 32'(s_cnt), 32'd15);
    chk("sat_cnt32_23", stall_cnt_o, 32'd23);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RISC-V core.
- Tracks in-flight load destinations in a scoreboard and raises the load-use stall the forwarding network in decode cannot cover.
- Arbitrates stall requests from id/ex/mem into one stall vector.
- Queues and issues branch/jump flushes, and counts stall cycles.

Parameters:
- REG_NUM, 32, number of architectural registers (x0 hardwired zero).
- ADDR_W, 5, register address width (matches RegAddrBus).
- PC_W, 32, instruction address width (matches InstAddrBus).
- CNT_W, 32, stall-cycle counter width.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-low reset.
- stallreq_from_id  in  1  decode stall request.
- stallreq_from_ex  in  1  multi-cycle execute stall request.
- stallreq_from_mem  in  1  memory-busy stall request.
- id_reg1_read_i  in  1  decode reads rs1.
- id_reg1_addr_i  in  ADDR_W  rs1 address.
- id_reg2_read_i  in  1  decode reads rs2.
- id_reg2_addr_i  in  ADDR_W  rs2 address.
- id_wreg_i  in  1  decoded instruction writes rd.
- id_wd_i  in  ADDR_W  rd address.
- id_is_load_i  in  1  decoded instruction is a load.
- mem_load_done_i  in  1  load data returned in mem this cycle.
- mem_load_wd_i  in  ADDR_W  destination of the returned load.
- flush_req_i  in  1  branch/jump redirect request (single-cycle pulse).
- flush_target_i  in  PC_W  redirect PC.
- stall  out  6  {wb,mem,ex,id,if,pc} hold bits (bit0 = pc).
- flush  out  1  kill if/id contents; pc loads new_pc.
- new_pc  out  PC_W  redirect target, valid when flush=1.
- sb_stall_o  out  1  scoreboard load-use hazard (observability).
- stall_cnt_o  out  CNT_W  cycles with stall!=0.

Behaviour:
- Reset (rst=0, async): scoreboard cleared, pend_flush=0, pend_pc=0, stall_cnt_o=0. Combinational outputs then read stall=0, flush=0, new_pc=0, sb_stall_o=0.
- Scoreboard: REG_NUM-bit vector `pending`; bit 0 is never set.
- sb_stall_o (combinational) = (id_reg1_read_i & pending[id_reg1_addr_i]) | (id_reg2_read_i & pending[id_reg2_addr_i]).
- Stall priority (combinational), highest first:
  - stallreq_from_mem → stall=6'b011111.
  - stallreq_from_ex → stall=6'b001111.
  - stallreq_from_id | sb_stall_o → stall=6'b000111.
  - none → stall=6'b000000.
- Issue: the decode instruction issues on a clock edge iff stall[2]=0 and flush=0.
- Set: on issue with id_wreg_i & id_is_load_i & id_wd_i!=0, pending[id_wd_i] ← 1.
- Clear: on mem_load_done_i with mem_load_wd_i!=0, pending[mem_load_wd_i] ← 0. This happens regardless of stall.
- Same-cycle set and clear of the same register: set wins.
- Latency: a load issued at edge N makes sb_stall_o visible from cycle N+1. A clear at edge M frees a dependent reader in cycle M+1.
- Flush arbitration:
  - Immediate: flush_req_i with no mem/ex stall → flush=1, new_pc=flush_target_i, stall=0 in that cycle (the id stall is overridden).
  - Deferred: flush_req_i while mem or ex stall is active → latch pend_flush=1, pend_pc=flush_target_i. flush=0 that cycle.
  - Pending issue: in the first cycle with no mem/ex stall, flush=1 and new_pc=pend_pc. pend_flush clears at the following edge.
  - Overwrite: a new flush_req_i while pend_flush=1 overwrites pend_pc.
  - Flush does not clear the scoreboard: loads already past id still complete.
- stall_cnt_o increments at each edge where stall!=0. It saturates at all-ones (no wrap).
- Reset asserted mid-operation clears all state immediately; no pending flush survives.

Test Plan:
- Reset: hold rst=0 with random inputs → stall=0, flush=0, new_pc=0, stall_cnt_o=0. After release, idle inputs keep stall=0.
- Load-use:
  - Issue load to x5, then decode reads rs1=x5 → stall=6'b000111 and sb_stall_o=1 until mem_load_done_i with wd=5.
  - Stall drops the cycle after that done.
  - stall_cnt_o equals the number of stalled cycles.
- x0 and clear/set collision:
  - A load to x0 never stalls a reader of x0.
  - mem_load_done_i wd=7 in the same cycle a new load to x7 issues → pending[7] stays 1.
- Priority: assert stallreq_from_id, stallreq_from_ex and stallreq_from_mem together → 6'b011111. Drop mem → 6'b001111. Drop ex → 6'b000111.
- Deferred flush:
  - With stallreq_from_ex=1, pulse flush_req_i with target 0x0000_0100 → flush=0.
  - Second pulse with target 0x0000_0200 → still flush=0 (overwrites pend_pc).
  - Release ex → exactly one cycle of flush=1, new_pc=0x0000_0200, no issue that cycle.
- Saturation: preload via long stall (CNT_W overridden to 4) → stall_cnt_o reaches 15 and holds.
